vga_rect_gen: RTL and testbench

VGA_RECT_GEN -- requirements
Module: vga_rect_gen

---
 rtl/vga_rect_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_rect_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_gen.sv
// VGA timing generator with a small stack of solid-colour rectangle layers.
// Layer geometry is double-buffered so that a frame is always drawn from one consistent set.
module vga_rect_gen #(
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter bit         HSYNC_POL = 1'b0,
    parameter bit         VSYNC_POL = 1'b0,
    parameter int         NUM_RECTS = 4,
    parameter logic [7:0] BG_COLOR  = 8'hFF,
    localparam int        IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [10:0]      wr_x0,
    input  logic [10:0]      wr_x1,
    input  logic [9:0]       wr_y0,
    input  logic [9:0]       wr_y1,
    input  logic [7:0]       wr_color,
    input  logic             wr_vis,
    output logic [7:0]       rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [10:0]      hcount,
    output logic [9:0]       vcount,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic [7:0]  r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_frame_start;

    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_copy;
    logic                 w_in_active;
    logic                 w_hs_on;
    logic                 w_vs_on;
    logic [NUM_RECTS-1:0] w_hit;
    logic [NUM_RECTS-1:0] w_wr_sel;
    logic [7:0]           w_lcolor [NUM_RECTS];
    logic [7:0]           w_pix_color;

    assign w_h_last    = (r_hcount == 11'(H_TOTAL - 1));
    assign w_v_last    = (r_vcount == 10'(V_TOTAL - 1));
    assign w_copy      = pix_en && w_h_last && w_v_last;
    assign w_in_active = (r_hcount < 11'(H_ACTIVE)) && (r_vcount < 10'(V_ACTIVE));
    assign w_hs_on     = (r_hcount >= 11'(HS_START)) && (r_hcount < 11'(HS_END));
    assign w_vs_on     = (r_vcount >= 10'(VS_START)) && (r_vcount < 10'(VS_END));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RECTS; gi++) begin : g_layer
            logic [10:0] r_sh_x0, r_sh_x1, r_lv_x0, r_lv_x1;
            logic [9:0]  r_sh_y0, r_sh_y1, r_lv_y0, r_lv_y1;
            logic [7:0]  r_sh_color, r_lv_color;
            logic        r_sh_vis, r_lv_vis;

            // Out-of-range indices never match any layer, so they are dropped here.
            assign w_wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sh_x0    <= '0;
                    r_sh_x1    <= '0;
                    r_sh_y0    <= '0;
                    r_sh_y1    <= '0;
                    r_sh_color <= '0;
                    r_sh_vis   <= 1'b0;
                end else if (w_wr_sel[gi]) begin
                    r_sh_x0    <= wr_x0;
                    r_sh_x1    <= wr_x1;
                    r_sh_y0    <= wr_y0;
                    r_sh_y1    <= wr_y1;
                    r_sh_color <= wr_color;
                    r_sh_vis   <= wr_vis;
                end
            end

            // A write landing on the copy cycle bypasses the shadow straight into the live set.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_lv_x0    <= '0;
                    r_lv_x1    <= '0;
                    r_lv_y0    <= '0;
                    r_lv_y1    <= '0;
                    r_lv_color <= '0;
                    r_lv_vis   <= 1'b0;
                end else if (w_copy) begin
                    if (w_wr_sel[gi]) begin
                        r_lv_x0    <= wr_x0;
                        r_lv_x1    <= wr_x1;
                        r_lv_y0    <= wr_y0;
                        r_lv_y1    <= wr_y1;
                        r_lv_color <= wr_color;
                        r_lv_vis   <= wr_vis;
                    end else begin
                        r_lv_x0    <= r_sh_x0;
                        r_lv_x1    <= r_sh_x1;
                        r_lv_y0    <= r_sh_y0;
                        r_lv_y1    <= r_sh_y1;
                        r_lv_color <= r_sh_color;
                        r_lv_vis   <= r_sh_vis;
                    end
                end
            end

            // Half-open bounds: an empty or inverted interval can never satisfy both compares.
            assign w_hit[gi] = r_lv_vis
                               && (r_hcount >= r_lv_x0) && (r_hcount < r_lv_x1)
                               && (r_vcount >= r_lv_y0) && (r_vcount < r_lv_y1);
            assign w_lcolor[gi] = r_lv_color;
        end
    endgenerate

    // Scan from the top index down so the lowest hitting index is the last to assign.
    always_comb begin
        w_pix_color = BG_COLOR;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_pix_color = w_lcolor[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_rgb         <= 8'h00;
            r_active      <= 1'b0;
            r_hsync       <= !HSYNC_POL;
            r_vsync       <= !VSYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (pix_en) begin
                r_rgb    <= w_in_active ? w_pix_color : 8'h00;
                r_active <= w_in_active;
                r_hsync  <= w_hs_on ? HSYNC_POL : !HSYNC_POL;
                r_vsync  <= w_vs_on ? VSYNC_POL : !VSYNC_POL;
                if (w_h_last) begin
                    r_hcount <= '0;
                    if (w_v_last) begin
                        r_vcount      <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_vcount <= r_vcount + 10'd1;
                    end
                end else begin
                    r_hcount <= r_hcount + 11'd1;
                end
            end
        end
    end

    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_rect_gen.sv
// Directed bench for vga_rect_gen using a shrunken raster (24x17) so whole frames stay short.
module tb_vga_rect_gen;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VA  = 12;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int NR  = 3;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [10:0] wr_x0, wr_x1;
    logic [9:0]  wr_y0, wr_y1;
    logic [7:0]  wr_color;
    logic        wr_vis;
    logic [7:0]  rgb;
    logic        hsync, vsync, active, frame_start;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    vga_rect_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .NUM_RECTS(NR), .BG_COLOR(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
        .wr_color(wr_color), .wr_vis(wr_vis),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .active(active),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        int         x;
        int         y;
        logic [7:0] rgb;
    } vec_t;

    vec_t       tbl [$];
    int         checks = 0;
    int         errors = 0;
    int         mx, my, px, py;
    logic [7:0] fb [VT][HT];
    logic [7:0] last_rgb;
    logic       last_hs, last_vs, last_act;
    logic [10:0] last_hc;
    logic [9:0]  last_vc;

    task automatic chk(input string name, input int x, input int y, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at (%0d,%0d): got %0h expected %0h", name, x, y, act, exp);
        end
    endtask

    task automatic snap_last();
        last_rgb = rgb; last_hs = hsync; last_vs = vsync;
        last_act = active; last_hc = hcount; last_vc = vcount;
    endtask

    // One clock; outputs sampled 1 time unit after the edge and checked against the bench's own raster model.
    task automatic tick();
        bit pe;
        bit act_exp;
        pe = pix_en;
        @(posedge clk);
        #1;
        if (pe) begin
            px = mx; py = my;
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            act_exp = (px < HA) && (py < VA);
            chk("hcount", px, py, hcount, mx);
            chk("vcount", px, py, vcount, my);
            chk("frame_start", px, py, frame_start, (mx == 0 && my == 0) ? 1 : 0);
            chk("active", px, py, active, act_exp);
            chk("hsync", px, py, hsync, (px >= HA + HFP && px < HA + HFP + HSW) ? 0 : 1);
            chk("vsync", px, py, vsync, (py >= VA + VFP && py < VA + VFP + VSW) ? 0 : 1);
            if (!act_exp) chk("blank_rgb", px, py, rgb, 0);
            fb[py][px] = rgb;
        end else begin
            chk("idle_frame_start", mx, my, frame_start, 0);
            chk("hold_rgb", mx, my, rgb, last_rgb);
            chk("hold_hsync", mx, my, hsync, last_hs);
            chk("hold_vsync", mx, my, vsync, last_vs);
            chk("hold_active", mx, my, active, last_act);
            chk("hold_hcount", mx, my, hcount, last_hc);
            chk("hold_vcount", mx, my, vcount, last_vc);
        end
        snap_last();
    endtask

    task automatic set_wr(input int idx, input int x0, input int x1, input int y0, input int y1,
                          input int col, input bit vis);
        wr_idx = 2'(idx); wr_x0 = 11'(x0); wr_x1 = 11'(x1);
        wr_y0 = 10'(y0); wr_y1 = 10'(y1); wr_color = 8'(col); wr_vis = vis;
    endtask

    task automatic do_write(input int idx, input int x0, input int x1, input int y0, input int y1,
                            input int col, input bit vis);
        set_wr(idx, x0, x1, y0, y1, col, vis);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // Runs exactly one frame from (0,0); the prepared write is strobed on tick wr_at (-1 for none).
    task automatic capture_frame(input int wr_at);
        for (int i = 0; i < FRAME; i++) begin
            wr_en = (i == wr_at);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run_to_frame_start();
        for (int n = 0; n < FRAME + 2 && !(mx == 0 && my == 0); n++) tick();
    endtask

    task automatic check_phase(input int p);
        foreach (tbl[k]) begin
            if (tbl[k].phase == p)
                chk($sformatf("phase%0d_rgb", p), tbl[k].x, tbl[k].y, fb[tbl[k].y][tbl[k].x], tbl[k].rgb);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, mx, my, rgb, 8'h00);
        chk({tag, "_active"}, mx, my, active, 0);
        chk({tag, "_hsync"}, mx, my, hsync, 1);
        chk({tag, "_vsync"}, mx, my, vsync, 1);
        chk({tag, "_hcount"}, mx, my, hcount, 0);
        chk({tag, "_vcount"}, mx, my, vcount, 0);
        chk({tag, "_frame_start"}, mx, my, frame_start, 0);
    endtask

    initial begin
        int hidden;
        int pulses;
        int t_first, t_second;

        // phase, x, y, expected rgb
        tbl = '{
            '{0, 0, 0, 8'hFF}, '{0, 15, 11, 8'hFF}, '{0, 16, 0, 8'h00}, '{0, 0, 12, 8'h00},
            '{0, 23, 16, 8'h00}, '{0, 7, 6, 8'hFF},
            '{1, 9, 7, 8'hFF}, '{1, 5, 6, 8'hFF}, '{1, 4, 7, 8'hFF},
            '{2, 4, 3, 8'hE0}, '{2, 9, 7, 8'hE0}, '{2, 9, 3, 8'hE0}, '{2, 10, 5, 8'hFF},
            '{2, 3, 5, 8'hFF}, '{2, 4, 8, 8'hFF}, '{2, 4, 2, 8'hFF},
            '{3, 3, 3, 8'h1C}, '{3, 6, 6, 8'h03}, '{3, 8, 8, 8'hFF}, '{3, 1, 1, 8'h1C},
            '{3, 4, 5, 8'h03}, '{3, 5, 4, 8'h03}, '{3, 7, 7, 8'hFF}, '{3, 6, 8, 8'hFF},
            '{3, 10, 10, 8'hFF}, '{3, 6, 0, 8'hFF},
            '{4, 10, 9, 8'hFF}, '{4, 6, 6, 8'h03},
            '{5, 10, 9, 8'h1F}, '{5, 11, 10, 8'h1F}, '{5, 12, 10, 8'hFF}, '{5, 11, 11, 8'hFF},
            '{5, 6, 6, 8'hFF}, '{5, 3, 3, 8'h1C},
            '{6, 10, 9, 8'h1F}, '{6, 3, 3, 8'h1C}, '{6, 20, 5, 8'h00}, '{6, 6, 6, 8'hFF},
            '{7, 0, 0, 8'hFF}, '{7, 3, 3, 8'hFF}, '{7, 10, 9, 8'hFF}, '{7, 11, 10, 8'hFF},
            '{7, 16, 3, 8'h00}
        };

        reset = 1'b1; pix_en = 1'b1; wr_en = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0, 1'b0);
        mx = 0; my = 0; px = 0; py = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        snap_last();

        // Default frame: background everywhere visible, blank elsewhere.
        capture_frame(-1);
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++)
                chk("default_pixel", x, y, fb[y][x], (x < HA && y < VA) ? 8'hFF : 8'h00);
        check_phase(0);

        // Mid-frame write must wait for the next frame.
        set_wr(0, 4, 10, 3, 8, 8'hE0, 1'b1);
        capture_frame(5 * HT + 5);
        check_phase(1);
        capture_frame(-1);
        check_phase(2);

        // Overlap priority, an empty-width layer and an out-of-range index.
        do_write(0, 0, 5, 0, 5, 8'h1C, 1'b1);
        do_write(1, 2, 7, 2, 7, 8'h03, 1'b1);
        do_write(2, 6, 6, 0, 12, 8'h55, 1'b1);
        do_write(3, 0, 16, 0, 12, 8'hAA, 1'b1);
        run_to_frame_start();
        capture_frame(-1);
        check_phase(3);
        hidden = 0;
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++)
                if (fb[y][x] == 8'h55 || fb[y][x] == 8'hAA) hidden++;
        chk("hidden_layer_pixels", 0, 0, hidden, 0);

        // Write on the very copy cycle shows up in the following frame.
        set_wr(1, 10, 12, 9, 11, 8'h1F, 1'b1);
        capture_frame(FRAME - 1);
        check_phase(4);
        capture_frame(-1);
        check_phase(5);

        // pix_en at half rate: frames take twice as many clocks and outputs hold on idle cycles.
        pulses = 0; t_first = -1; t_second = -1;
        for (int c = 0; c < 4 * FRAME; c++) begin
            pix_en = (c % 2 == 0);
            tick();
            if (frame_start) begin
                pulses++;
                if (t_first < 0) t_first = c;
                else if (t_second < 0) t_second = c;
            end
        end
        pix_en = 1'b1;
        chk("toggle_pulse_count", mx, my, pulses, 2);
        chk("toggle_frame_period", mx, my, t_second - t_first, 2 * FRAME);
        check_phase(6);

        // Asynchronous reset in the middle of the visible area.
        for (int n = 0; n < FRAME && !(mx == 10 && my == 7); n++) tick();
        chk("pre_reset_active", mx, my, active, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        reset = 1'b0;
        mx = 0; my = 0;
        snap_last();
        capture_frame(-1);
        check_phase(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
